// File: rtl/ifid_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls and imem data into the stage,
// fetch address, IF/ID register contents and event counters out of it.
interface ifid_fetch_stage_if #(
  parameter int N = 32
);
  logic         stall;
  logic         flush;
  logic [N-1:0] branch_target;
  logic [N-1:0] imem_instr;
  logic [N-1:0] pc;
  logic [N-1:0] ifid_pc;
  logic [N-1:0] ifid_instr;
  logic         ifid_valid;
  logic [7:0]   stall_cnt;
  logic [7:0]   flush_cnt;

  // The fetch stage itself
  modport master (
    input  stall, flush, branch_target, imem_instr,
    output pc, ifid_pc, ifid_instr, ifid_valid, stall_cnt, flush_cnt
  );

  // Surrounding pipeline: hazard unit, EX redirect, instruction memory, decode
  modport slave (
    output stall, flush, branch_target, imem_instr,
    input  pc, ifid_pc, ifid_instr, ifid_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ifid_fetch_stage.sv
// Instruction fetch stage with PC register and IF/ID pipeline register.
// Redirect (flush) beats stall beats sequential advance. A flush inserts a
// NOP bubble; a stall freezes PC and IF/ID. Every output comes from a flop.
module ifid_fetch_stage #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [N-1:0] NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  ifid_fetch_stage_if.master bus
);

  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] ifid_pc_q, ifid_pc_d;
  logic [N-1:0] ifid_instr_q, ifid_instr_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [7:0]   stall_cnt_q, stall_cnt_d;
  logic [7:0]   flush_cnt_q, flush_cnt_d;

  // Next-state selection: hold by default, then apply flush > stall > advance
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (bus.flush) begin
      // Redirect targets are word aligned; the low bits are dropped outright
      pc_d         = {bus.branch_target[N-1:2], 2'b00};
      ifid_instr_d = NOP;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
      flush_cnt_d  = (flush_cnt_q == 8'hFF) ? flush_cnt_q : flush_cnt_q + 8'd1;
    end else if (bus.stall) begin
      stall_cnt_d  = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
    end else begin
      // Natural wrap at the top of the address space is intended
      pc_d         = pc_q + N'(4);
      ifid_instr_d = bus.imem_instr;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the architectural reset state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= 8'd0;
      flush_cnt_q  <= 8'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
